operand_stream_reader: RTL and testbench

Read-side sequencer for the matrix operand register. It accepts a start command with a matrix dimension and an order (row-major or transposed), and generates element addresses into the operand register's address port. It absorbs the register's one-cycle registered-read latency and presents the elements as a valid/ready stream to the downstream compute datapath, with a last-element flag and a done pulse.

---
 rtl/operand_stream_reader.sv | 174 +++++++++++++++++
 tb/tb_operand_stream_reader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/operand_stream_reader.sv
// Read-side sequencer for the matrix operand register: walks an N x N matrix in
// row-major or transposed order and streams the elements out through a 2-entry FIFO.
module operand_stream_reader #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4,
   parameter int MAX_DIM    = 4,
   parameter int DIM_WIDTH  = 3
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic [DIM_WIDTH-1:0]  dim_i,
   input  logic                  transpose_i,
   output logic [ADDR_WIDTH-1:0] addr_Mat_o,
   input  logic [DATA_WIDTH-1:0] read_data_Mat_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic                  last_o,
   output logic                  busy_o,
   output logic                  done_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [DIM_WIDTH-1:0]  n_q, n_d;
   logic                  trans_q, trans_d;
   logic [DIM_WIDTH-1:0]  outer_q, outer_d;
   logic [DIM_WIDTH-1:0]  inner_q, inner_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  inflight_q, inflight_d;
   logic                  inflight_last_q, inflight_last_d;
   logic [DATA_WIDTH-1:0] fifo_data_q [2];
   logic [DATA_WIDTH-1:0] fifo_data_d [2];
   logic                  fifo_last_q [2];
   logic                  fifo_last_d [2];
   logic                  wr_ptr_q, wr_ptr_d;
   logic                  rd_ptr_q, rd_ptr_d;
   logic [1:0]            count_q, count_d;
   logic                  done_q, done_d;

   logic                  pop;
   logic                  issue;
   logic                  is_last;
   logic [2:0]            occupancy;
   logic [DIM_WIDTH-1:0]  dim_clamped;
   logic [DIM_WIDTH-1:0]  row;
   logic [DIM_WIDTH-1:0]  col;
   logic [ADDR_WIDTH-1:0] cur_addr;

   assign valid_o    = (count_q != 2'd0);
   assign data_o     = fifo_data_q[rd_ptr_q];
   assign last_o     = valid_o & fifo_last_q[rd_ptr_q];
   assign busy_o     = (state_q != IDLE) | done_q;
   assign done_o     = done_q;
   assign pop        = valid_o & ready_i;
   assign addr_Mat_o = issue ? cur_addr : addr_q;

   // Issue only when the FIFO plus the read still in the register's pipeline
   // leave room, so a stalled consumer can never cause an overflow.
   always_comb begin
      dim_clamped = (dim_i > DIM_WIDTH'(MAX_DIM)) ? DIM_WIDTH'(MAX_DIM) : dim_i;
      row         = trans_q ? inner_q : outer_q;
      col         = trans_q ? outer_q : inner_q;
      cur_addr    = ADDR_WIDTH'(row) * ADDR_WIDTH'(MAX_DIM) + ADDR_WIDTH'(col);
      occupancy   = 3'(count_q) + 3'(inflight_q) - 3'(pop);
      issue       = (state_q == ISSUE) && (occupancy < 3'd2);
      is_last     = (inner_q == n_q - DIM_WIDTH'(1)) && (outer_q == n_q - DIM_WIDTH'(1));
   end

   always_comb begin
      state_d         = state_q;
      n_d             = n_q;
      trans_d         = trans_q;
      outer_d         = outer_q;
      inner_d         = inner_q;
      addr_d          = addr_q;
      inflight_d      = issue;
      inflight_last_d = issue & is_last;
      fifo_data_d     = fifo_data_q;
      fifo_last_d     = fifo_last_q;
      wr_ptr_d        = wr_ptr_q;
      rd_ptr_d        = rd_ptr_q;
      count_d         = count_q + {1'b0, inflight_q} - {1'b0, pop};
      done_d          = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               if (dim_clamped == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = ISSUE;
                  n_d     = dim_clamped;
                  trans_d = transpose_i;
                  outer_d = '0;
                  inner_d = '0;
               end
            end
         end
         ISSUE: begin
            if (issue) begin
               addr_d = cur_addr;
               if (inner_q == n_q - DIM_WIDTH'(1)) begin
                  inner_d = '0;
                  outer_d = outer_q + DIM_WIDTH'(1);
               end else begin
                  inner_d = inner_q + DIM_WIDTH'(1);
               end
               if (is_last) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (pop && last_o) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Read data arrives one cycle after its address, tagged with its last flag.
      if (inflight_q) begin
         fifo_data_d[wr_ptr_q] = read_data_Mat_i;
         fifo_last_d[wr_ptr_q] = inflight_last_q;
         wr_ptr_d              = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q         <= IDLE;
         n_q             <= '0;
         trans_q         <= 1'b0;
         outer_q         <= '0;
         inner_q         <= '0;
         addr_q          <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         fifo_data_q     <= '{default: '0};
         fifo_last_q     <= '{default: 1'b0};
         wr_ptr_q        <= 1'b0;
         rd_ptr_q        <= 1'b0;
         count_q         <= '0;
         done_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         n_q             <= n_d;
         trans_q         <= trans_d;
         outer_q         <= outer_d;
         inner_q         <= inner_d;
         addr_q          <= addr_d;
         inflight_q      <= inflight_d;
         inflight_last_q <= inflight_last_d;
         fifo_data_q     <= fifo_data_d;
         fifo_last_q     <= fifo_last_d;
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         count_q         <= count_d;
         done_q          <= done_d;
      end
   end

endmodule

// File: tb/tb_operand_stream_reader.sv
// Self-checking bench for operand_stream_reader: a registered-read operand register
// holding a+100 at address a, and an element-order model built from plain loops.
module tb_operand_stream_reader;

   localparam int DW  = 32;
   localparam int AW  = 4;
   localparam int MD  = 4;
   localparam int DMW = 3;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          start_i;
   logic [DMW-1:0] dim_i;
   logic          transpose_i;
   logic [AW-1:0] addr_Mat_o;
   logic [DW-1:0] read_data_Mat_i;
   logic [DW-1:0] data_o;
   logic          valid_o;
   logic          ready_i;
   logic          last_o;
   logic          busy_o;
   logic          done_o;

   int total_checks  = 0;
   int passed_checks = 0;

   always #5 clk_i = ~clk_i;

   // Operand register: one-cycle registered read of mem[a] = a + 100.
   always @(posedge clk_i) read_data_Mat_i <= 32'(addr_Mat_o) + 32'd100;

   operand_stream_reader #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .MAX_DIM(MD),
      .DIM_WIDTH(DMW)
   ) dut (
      .clk_i(clk_i),
      .rst_ni(rst_ni),
      .start_i(start_i),
      .dim_i(dim_i),
      .transpose_i(transpose_i),
      .addr_Mat_o(addr_Mat_o),
      .read_data_Mat_i(read_data_Mat_i),
      .data_o(data_o),
      .valid_o(valid_o),
      .ready_i(ready_i),
      .last_o(last_o),
      .busy_o(busy_o),
      .done_o(done_o)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_checks++;
      assert (obs === exp) passed_checks++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_addr"},  32'(addr_Mat_o), 0);
      checkOutput({tag, "_data"},  data_o, 0);
      checkOutput({tag, "_valid"}, 32'(valid_o), 0);
      checkOutput({tag, "_last"},  32'(last_o), 0);
      checkOutput({tag, "_busy"},  32'(busy_o), 0);
      checkOutput({tag, "_done"},  32'(done_o), 0);
   endtask

   // One matrix read: builds the expected element order, drives start, then
   // watches the stream cycle by cycle. abort_after > 0 pulls reset after that beat.
   task automatic applyStimulus(input int dim, input bit trans, input bit rand_ready,
                                input bit mid_start, input int abort_after);
      logic [31:0] exp_q[$];
      int          exp_addr[$];
      int          n, n_elems, beats, first_valid, last_hs, done_count, done_cycle, stall_left;
      bit          prev_stall, aborted;
      logic [31:0] prev_data;
      logic        prev_last;
      n = (dim > MD) ? MD : dim;
      for (int o = 0; o < n; o++) begin
         for (int i = 0; i < n; i++) begin
            int r, c;
            r = trans ? i : o;
            c = trans ? o : i;
            exp_addr.push_back(r * MD + c);
            exp_q.push_back(32'(r * MD + c + 100));
         end
      end
      n_elems     = exp_q.size();
      beats       = 0;
      first_valid = -1;
      last_hs     = -1;
      done_count  = 0;
      done_cycle  = -1;
      stall_left  = 0;
      prev_stall  = 1'b0;
      prev_data   = '0;
      prev_last   = 1'b0;
      aborted     = 1'b0;
      $display("[TB] start dim=%0d transpose=%0d random_ready=%0d mid_start=%0d abort_after=%0d",
               dim, trans, rand_ready, mid_start, abort_after);

      @(posedge clk_i); #1;
      start_i     = 1'b1;
      dim_i       = DMW'(dim);
      transpose_i = trans;
      ready_i     = 1'b1;

      for (int k = 0; k < 400; k++) begin
         @(posedge clk_i); #1;
         start_i     = mid_start && (k == 6);
         dim_i       = DMW'($urandom);
         transpose_i = 1'($urandom);
         if (!rand_ready) begin
            ready_i = 1'b1;
         end else if (stall_left > 0) begin
            ready_i = 1'b0;
            stall_left--;
         end else begin
            int pick;
            pick = int'($urandom_range(0, 9));
            if (pick == 0) begin
               ready_i    = 1'b0;
               stall_left = 4;
            end else begin
               ready_i = (pick > 3);
            end
         end

         @(negedge clk_i);
         if (k == 0) begin
            checkOutput("busy_first_cycle", 32'(busy_o), 1);
            checkOutput("valid_first_cycle", 32'(valid_o), 0);
         end
         if (!rand_ready && k < n_elems) checkOutput("addr", 32'(addr_Mat_o), 32'(exp_addr[k]));
         if (valid_o && first_valid < 0) first_valid = k;
         if (prev_stall) begin
            checkOutput("stall_valid", 32'(valid_o), 1);
            checkOutput("stall_data", data_o, prev_data);
            checkOutput("stall_last", 32'(last_o), 32'(prev_last));
         end
         if (done_o) begin
            done_count++;
            done_cycle = k;
         end
         if (done_cycle >= 0 && k == done_cycle + 1) checkOutput("busy_after_done", 32'(busy_o), 0);
         if (valid_o && ready_i) begin
            beats++;
            last_hs = k;
            if (exp_q.size() == 0) begin
               checkOutput("extra_beat", beats, n_elems);
            end else begin
               checkOutput("data", data_o, exp_q.pop_front());
               checkOutput("last", 32'(last_o), 32'(exp_q.size() == 0));
            end
            if (abort_after > 0 && beats == abort_after) begin
               aborted = 1'b1;
               break;
            end
         end
         prev_stall = valid_o && !ready_i;
         prev_data  = data_o;
         prev_last  = last_o;
         if (done_cycle >= 0 && k >= done_cycle + 2) break;
      end

      if (aborted) begin
         @(posedge clk_i); #1;
         rst_ni = 1'b0;
         #1;
         checkResetValues("async_reset");
         for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            checkOutput("reset_done", 32'(done_o), 0);
            checkOutput("reset_valid", 32'(valid_o), 0);
         end
         rst_ni = 1'b1;
         for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            checkOutput("post_reset_done", 32'(done_o), 0);
            checkOutput("post_reset_busy", 32'(busy_o), 0);
         end
      end else begin
         checkOutput("first_valid_cycle", 32'(first_valid), (n > 0) ? 32'd2 : 32'hFFFF_FFFF);
         checkOutput("beat_count", beats, n_elems);
         checkOutput("done_count", done_count, 1);
         checkOutput("done_cycle", done_cycle, last_hs + 1);
      end
   endtask

   initial begin
      rst_ni      = 1'b0;
      start_i     = 1'b0;
      dim_i       = '0;
      transpose_i = 1'b0;
      ready_i     = 1'b0;
      repeat (2) @(negedge clk_i);
      checkResetValues("reset");
      rst_ni = 1'b1;

      applyStimulus(4, 1'b0, 1'b0, 1'b0, 0);
      applyStimulus(3, 1'b1, 1'b0, 1'b0, 0);
      applyStimulus(4, 1'b0, 1'b1, 1'b0, 0);
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 0);
      applyStimulus(7, 1'b0, 1'b0, 1'b0, 0);
      applyStimulus(4, 1'b0, 1'b0, 1'b1, 0);
      applyStimulus(4, 1'b0, 1'b1, 1'b0, 5);
      applyStimulus(2, 1'b0, 1'b0, 1'b0, 0);

      $display("%0d/%0d checks passed", passed_checks, total_checks);
      $finish;
   end

endmodule
